l2_request_tracker: RTL and testbench



---
 rtl/l2_tracker_pkg.sv | 27 ++
 rtl/l2_request_tracker_free_tag_finder.sv | 25 ++
 rtl/l2_request_tracker.sv | 147 ++++++++++++++
 tb/tb_l2_request_tracker.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_tracker_pkg.sv
// Shared width defaults and packed record types for the L2 request tracker.
// Tracker instances take their parameter defaults from the constants here.
package l2_tracker_pkg;

  localparam int default_num_L1s      = 2;
  localparam int default_num_L1s_log  = 1;
  localparam int default_addr_width   = 32;
  localparam int default_data_width   = 256;
  localparam int default_cpu_id_width = 2;
  localparam int default_tag_width    = 2;

  // Per-tag bookkeeping needed to route a read response back to its requester
  typedef struct packed {
    logic [default_addr_width-1:0]   addr;
    logic [default_cpu_id_width-1:0] id;
    logic [default_num_L1s_log-1:0]  which_L1;
  } l2_entry_t;

  typedef struct packed {
    logic                            valid;
    logic                            rw;
    logic [default_addr_width-1:0]   addr;
    logic [default_data_width-1:0]   data;
    logic [default_tag_width-1:0]    tag;
  } l2_issue_t;

endpackage

// File: rtl/l2_request_tracker_free_tag_finder.sv
// Lowest-index free tag finder: combinational priority encoder over the busy
// vector, reporting whether any tag is free and which one.
module free_tag_finder #(
  parameter int tag_width = 2
) (
  input  logic [(1<<tag_width)-1:0] busy,
  output logic                      found,
  output logic [tag_width-1:0]      tag
);

  localparam int depth = 1 << tag_width;

  // Scanning from the top down lets the lowest free index win the last write
  always_comb begin
    found = 1'b0;
    tag   = '0;
    for (int i = depth - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        found = 1'b1;
        tag   = tag_width'(i);
      end
    end
  end

endmodule

// File: rtl/l2_request_tracker.sv
// Registers arbiter requests toward the L2, tags reads in a small outstanding
// table, and turns tagged L2 read responses into L2-to-L1 return packets.
module l2_request_tracker
  import l2_tracker_pkg::*;
#(
  parameter int num_L1s      = default_num_L1s,
  parameter int num_L1s_log  = default_num_L1s_log,
  parameter int addr_width   = default_addr_width,
  parameter int data_width   = default_data_width,
  parameter int cpu_id_width = default_cpu_id_width,
  parameter int tag_width    = default_tag_width
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_rw,
  input  logic [addr_width-1:0]   req_addr,
  input  logic [data_width-1:0]   req_data,
  input  logic [cpu_id_width-1:0] req_id,
  input  logic [num_L1s_log-1:0]  req_which_L1,
  output logic                    req_accept,
  output logic                    mem_valid,
  output logic                    mem_rw,
  output logic [addr_width-1:0]   mem_addr,
  output logic [data_width-1:0]   mem_data,
  output logic [tag_width-1:0]    mem_tag,
  input  logic                    mem_ready,
  input  logic                    resp_valid,
  input  logic [tag_width-1:0]    resp_tag,
  input  logic [data_width-1:0]   resp_data,
  output logic                    ret_valid,
  output logic                    ret_rw,
  output logic [addr_width-1:0]   ret_addr,
  output logic [data_width-1:0]   ret_data,
  output logic [cpu_id_width-1:0] ret_id,
  output logic [num_L1s_log-1:0]  ret_which_L1,
  output logic [tag_width:0]      outstanding,
  output logic                    table_full,
  output logic                    tag_error
);

  localparam int depth = 1 << tag_width;

  typedef struct packed {
    logic [addr_width-1:0]   addr;
    logic [cpu_id_width-1:0] id;
    logic [num_L1s_log-1:0]  which_L1;
  } entry_t;

  if (num_L1s > (1 << num_L1s_log)) begin : g_width_check
    $error("num_L1s_log too narrow for num_L1s");
  end

  logic [depth-1:0]     busy;
  entry_t               entry_table [depth];
  logic                 issue_free;
  logic                 alloc_found;
  logic [tag_width-1:0] alloc_tag;
  logic                 alloc_read;
  logic                 resp_hit;

  free_tag_finder #(.tag_width(tag_width)) u_free_tag_finder (
    .busy  (busy),
    .found (alloc_found),
    .tag   (alloc_tag)
  );

  assign issue_free = !mem_valid | mem_ready;
  assign req_accept = req_valid & issue_free & (req_rw | alloc_found);
  assign alloc_read = req_accept & !req_rw;
  assign resp_hit   = resp_valid & busy[resp_tag];

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < depth; i++) begin
      outstanding = outstanding + {{tag_width{1'b0}}, busy[i]};
    end
  end

  assign table_full = (outstanding == (tag_width+1)'(depth));

  // Allocation reads the pre-edge busy vector, so a tag freed by a response
  // this cycle can never collide with the tag being allocated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < depth; i++) begin
        if (resp_hit && resp_tag == tag_width'(i)) begin
          busy[i] <= 1'b0;
        end else if (alloc_read && alloc_tag == tag_width'(i)) begin
          busy[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_read) begin
      entry_table[alloc_tag] <= '{addr: req_addr, id: req_id, which_L1: req_which_L1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_tag   <= '0;
    end else if (req_accept) begin
      mem_valid <= 1'b1;
      mem_rw    <= req_rw;
      mem_addr  <= req_addr;
      mem_data  <= req_data;
      mem_tag   <= req_rw ? '0 : alloc_tag;
    end else if (mem_ready) begin
      mem_valid <= 1'b0;
    end
  end

  // The return path has no backpressure, so ret_valid is a one-cycle pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ret_valid    <= 1'b0;
      ret_rw       <= 1'b0;
      ret_addr     <= '0;
      ret_data     <= '0;
      ret_id       <= '0;
      ret_which_L1 <= '0;
      tag_error    <= 1'b0;
    end else begin
      ret_valid <= resp_hit;
      if (resp_hit) begin
        ret_rw       <= 1'b0;
        ret_addr     <= entry_table[resp_tag].addr;
        ret_data     <= resp_data;
        ret_id       <= entry_table[resp_tag].id;
        ret_which_L1 <= entry_table[resp_tag].which_L1;
      end
      if (resp_valid && !busy[resp_tag]) begin
        tag_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l2_request_tracker.sv
// Directed testbench for l2_request_tracker with a transaction-level model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_l2_request_tracker;
  import l2_tracker_pkg::*;

  localparam int aw    = 32;
  localparam int dw    = 256;
  localparam int iw    = 2;
  localparam int lw    = 1;
  localparam int tw    = 2;
  localparam int depth = 4;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_rw;
  logic [aw-1:0] req_addr;
  logic [dw-1:0] req_data;
  logic [iw-1:0] req_id;
  logic [lw-1:0] req_which_L1;
  logic          req_accept;
  logic          mem_valid;
  logic          mem_rw;
  logic [aw-1:0] mem_addr;
  logic [dw-1:0] mem_data;
  logic [tw-1:0] mem_tag;
  logic          mem_ready;
  logic          resp_valid;
  logic [tw-1:0] resp_tag;
  logic [dw-1:0] resp_data;
  logic          ret_valid;
  logic          ret_rw;
  logic [aw-1:0] ret_addr;
  logic [dw-1:0] ret_data;
  logic [iw-1:0] ret_id;
  logic [lw-1:0] ret_which_L1;
  logic [tw:0]   outstanding;
  logic          table_full;
  logic          tag_error;

  int checks = 0;
  int errors = 0;

  l2_request_tracker dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_rw       (req_rw),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_id       (req_id),
    .req_which_L1 (req_which_L1),
    .req_accept   (req_accept),
    .mem_valid    (mem_valid),
    .mem_rw       (mem_rw),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_tag      (mem_tag),
    .mem_ready    (mem_ready),
    .resp_valid   (resp_valid),
    .resp_tag     (resp_tag),
    .resp_data    (resp_data),
    .ret_valid    (ret_valid),
    .ret_rw       (ret_rw),
    .ret_addr     (ret_addr),
    .ret_data     (ret_data),
    .ret_id       (ret_id),
    .ret_which_L1 (ret_which_L1),
    .outstanding  (outstanding),
    .table_full   (table_full),
    .tag_error    (tag_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: which tags are in flight and what each remembers, plus the
  // request currently offered to the L2 and the last return packet.
  bit            m_busy [depth];
  l2_entry_t     m_entry [depth];
  bit            m_mem_valid;
  bit            m_mem_rw;
  logic [aw-1:0] m_mem_addr;
  logic [dw-1:0] m_mem_data;
  logic [tw-1:0] m_mem_tag;
  bit            m_ret_valid;
  logic [aw-1:0] m_ret_addr;
  logic [dw-1:0] m_ret_data;
  logic [iw-1:0] m_ret_id;
  logic [lw-1:0] m_ret_which;
  bit            m_tag_error;

  task automatic check_output(input string name, input logic [dw-1:0] actual,
                              input logic [dw-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < depth; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  function automatic bit model_accept();
    return req_valid && (!m_mem_valid || mem_ready) && (req_rw || model_count() < depth);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < depth; i++) m_busy[i] = 1'b0;
    m_mem_valid = 1'b0;
    m_ret_valid = 1'b0;
    m_tag_error = 1'b0;
  endtask

  task automatic model_step();
    bit acc;
    bit hit;
    int free_tag;
    if (!reset) begin
      model_clear();
      return;
    end
    acc = model_accept();
    free_tag = -1;
    for (int i = depth - 1; i >= 0; i--) if (!m_busy[i]) free_tag = i;
    hit = resp_valid && m_busy[resp_tag];
    m_ret_valid = hit;
    if (hit) begin
      m_ret_addr  = m_entry[resp_tag].addr;
      m_ret_id    = m_entry[resp_tag].id;
      m_ret_which = m_entry[resp_tag].which_L1;
      m_ret_data  = resp_data;
      m_busy[resp_tag] = 1'b0;
    end
    if (resp_valid && !hit) m_tag_error = 1'b1;
    if (acc) begin
      m_mem_valid = 1'b1;
      m_mem_rw    = req_rw;
      m_mem_addr  = req_addr;
      m_mem_data  = req_data;
      m_mem_tag   = req_rw ? '0 : tw'(free_tag);
      if (!req_rw) begin
        m_busy[free_tag]  = 1'b1;
        m_entry[free_tag] = '{addr: req_addr, id: req_id, which_L1: req_which_L1};
      end
    end else if (mem_ready) begin
      m_mem_valid = 1'b0;
    end
  endtask

  task automatic compare_outputs();
    if (!reset) model_clear();
    check_output("cyc_req_accept", req_accept, model_accept());
    check_output("cyc_mem_valid", mem_valid, m_mem_valid);
    if (m_mem_valid) begin
      check_output("cyc_mem_rw", mem_rw, m_mem_rw);
      check_output("cyc_mem_addr", mem_addr, m_mem_addr);
      check_output("cyc_mem_data", mem_data, m_mem_data);
      check_output("cyc_mem_tag", mem_tag, m_mem_tag);
    end
    check_output("cyc_ret_valid", ret_valid, m_ret_valid);
    if (m_ret_valid) begin
      check_output("cyc_ret_rw", ret_rw, 0);
      check_output("cyc_ret_addr", ret_addr, m_ret_addr);
      check_output("cyc_ret_data", ret_data, m_ret_data);
      check_output("cyc_ret_id", ret_id, m_ret_id);
      check_output("cyc_ret_which_L1", ret_which_L1, m_ret_which);
    end
    check_output("cyc_outstanding", outstanding, model_count());
    check_output("cyc_table_full", table_full, model_count() == depth);
    check_output("cyc_tag_error", tag_error, m_tag_error);
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      compare_outputs();
    end
  end

  task automatic apply_stimulus(input bit v, input bit rw, input logic [aw-1:0] a,
                                input logic [dw-1:0] d, input logic [iw-1:0] id,
                                input logic [lw-1:0] wl);
    req_valid    = v;
    req_rw       = rw;
    req_addr     = a;
    req_data     = d;
    req_id       = id;
    req_which_L1 = wl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [dw-1:0] ab_line;
  logic [dw-1:0] line1;

  initial begin
    ab_line = {32{8'hAB}};
    line1   = {8{32'h1111_0001}};
    reset = 1'b0;
    mem_ready = 1'b0;
    resp_valid = 1'b0;
    resp_tag = '0;
    resp_data = '0;
    apply_stimulus(0, 0, '0, '0, '0, '0);
    tick();
    tick();
    check_output("init_mem_valid", mem_valid, 0);
    check_output("init_outstanding", outstanding, 0);
    reset = 1'b1;
    tick();

    // Single read and its response
    mem_ready = 1'b1;
    apply_stimulus(1, 0, 32'h100, {8{32'h0000_5A5A}}, 2'd2, 1'b1);
    #1 check_output("single_accept", req_accept, 1);
    tick();
    apply_stimulus(0, 0, '0, '0, '0, '0);
    check_output("single_mem_valid", mem_valid, 1);
    check_output("single_mem_tag", mem_tag, 0);
    check_output("single_mem_addr", mem_addr, 32'h100);
    check_output("single_outstanding", outstanding, 1);
    resp_valid = 1'b1; resp_tag = 2'd0; resp_data = ab_line;
    tick();
    resp_valid = 1'b0;
    check_output("single_ret_valid", ret_valid, 1);
    check_output("single_ret_addr", ret_addr, 32'h100);
    check_output("single_ret_id", ret_id, 2);
    check_output("single_ret_which", ret_which_L1, 1);
    check_output("single_ret_data", ret_data, ab_line);
    check_output("single_mem_drop", mem_valid, 0);
    tick();
    check_output("single_ret_pulse", ret_valid, 0);

    // Fill the table with four reads
    for (int i = 0; i < depth; i++) begin
      apply_stimulus(1, 0, aw'(32'h200 + i * 64), dw'(i + 1), iw'(i), lw'(i));
      tick();
      check_output("full_tag", mem_tag, dw'(i));
    end
    apply_stimulus(1, 0, 32'h400, dw'(99), 2'd3, 1'b0);
    #1;
    check_output("full_flag", table_full, 1);
    check_output("full_outstanding", outstanding, 4);
    check_output("full_read_blocked", req_accept, 0);
    apply_stimulus(1, 1, 32'h300, {8{32'hC0FF_EE00}}, 2'd0, 1'b0);
    #1 check_output("full_write_accept", req_accept, 1);
    tick();
    check_output("full_write_rw", mem_rw, 1);
    check_output("full_write_tag", mem_tag, 0);
    check_output("full_write_addr", mem_addr, 32'h300);

    // Response on tag 1 and a read offered on the same edge
    apply_stimulus(1, 0, 32'h400, dw'(99), 2'd3, 1'b0);
    resp_valid = 1'b1; resp_tag = 2'd1; resp_data = line1;
    #1 check_output("same_edge_blocked", req_accept, 0);
    tick();
    resp_valid = 1'b0;
    check_output("same_edge_outst3", outstanding, 3);
    check_output("same_edge_ret_addr", ret_addr, 32'h240);
    check_output("same_edge_ret_data", ret_data, line1);
    #1 check_output("same_edge_accept", req_accept, 1);
    tick();
    apply_stimulus(0, 0, '0, '0, '0, '0);
    check_output("same_edge_tag", mem_tag, 1);
    check_output("same_edge_outst4", outstanding, 4);

    // Stall with a write pending behind the held read
    mem_ready = 1'b0;
    apply_stimulus(1, 1, 32'h500, {8{32'h5555_AAAA}}, 2'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1 check_output("stall_accept", req_accept, 0);
      tick();
      check_output("stall_mem_valid", mem_valid, 1);
      check_output("stall_mem_addr", mem_addr, 32'h400);
      check_output("stall_mem_tag", mem_tag, 1);
    end
    mem_ready = 1'b1;
    #1 check_output("stall_release_accept", req_accept, 1);
    tick();
    apply_stimulus(0, 0, '0, '0, '0, '0);
    check_output("stall_issue_rw", mem_rw, 1);
    check_output("stall_issue_addr", mem_addr, 32'h500);

    // Reset in the middle of traffic
    mem_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check_output("rst_mem_valid", mem_valid, 0);
    check_output("rst_mem_addr", mem_addr, 0);
    check_output("rst_outstanding", outstanding, 0);
    check_output("rst_table_full", table_full, 0);
    check_output("rst_ret_valid", ret_valid, 0);
    check_output("rst_ret_addr", ret_addr, 0);
    check_output("rst_req_accept", req_accept, 0);
    tick();
    tick();
    reset = 1'b1;
    mem_ready = 1'b1;
    apply_stimulus(1, 0, 32'h600, dw'(6), 2'd1, 1'b0);
    tick();
    apply_stimulus(0, 0, '0, '0, '0, '0);
    check_output("post_rst_valid", mem_valid, 1);
    check_output("post_rst_tag", mem_tag, 0);
    check_output("post_rst_outstanding", outstanding, 1);

    // Response on an idle tag
    resp_valid = 1'b1; resp_tag = 2'd3; resp_data = ab_line;
    tick();
    resp_valid = 1'b0;
    check_output("idle_ret_valid", ret_valid, 0);
    check_output("idle_tag_error", tag_error, 1);
    check_output("idle_outstanding", outstanding, 1);
    tick();
    tick();
    tick();
    check_output("idle_sticky", tag_error, 1);
    reset = 1'b0;
    #1 check_output("idle_cleared", tag_error, 0);
    tick();
    reset = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
